// File: rtl/csr_trap_ctrl.sv
// -----------------------------------------------------------------------------
// csr_trap_ctrl -- machine-mode trap sequencer for the CSR file.
//
// Accepts a synchronous exception, a machine external interrupt (only when
// mstatus.MIE is set) or an mret from the core while idle. It then drives the
// single CSR write port one write per cycle to save or restore trap state, and
// holds the pipeline for the whole sequence. The sequence ends with a one-cycle
// PC redirect to the trap vector or to the return address.
//
// Optional build macro:
//   CSR_TRAP_TVAL_EN  adds a W_TVAL state that writes mtval (0x343) between the
//                     mcause and mstatus writes. When undefined, mtval is never
//                     written and exc_tval is unused.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   exc_req/_cause    exception request (level) and 4-bit cause code
//   exc_pc, exc_tval  faulting PC (also the interrupt resume PC), trap value
//   irq_req           machine external interrupt pending (level)
//   mret_req          mret retiring
//   mstatus_rd, mtvec_rd, mepc_rd   current CSR values, read combinationally
//   csr_we/addr/wdata CSR write port, zero outside the write states
//   stall             pipeline hold, high in every non-idle state
//   redir_valid/pc    one-cycle redirect strobe and target, pc zero otherwise
// -----------------------------------------------------------------------------
module csr_trap_ctrl #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         exc_req,
  input  logic [3:0]   exc_cause,
  input  logic [N-1:0] exc_pc,
  input  logic [N-1:0] exc_tval,
  input  logic         irq_req,
  input  logic         mret_req,
  input  logic [N-1:0] mstatus_rd,
  input  logic [N-1:0] mtvec_rd,
  input  logic [N-1:0] mepc_rd,
  output logic         csr_we,
  output logic [11:0]  csr_addr,
  output logic [N-1:0] csr_wdata,
  output logic         stall,
  output logic         redir_valid,
  output logic [N-1:0] redir_pc
);

  localparam logic [11:0]  ADDR_MSTATUS = 12'h300;
  localparam logic [11:0]  ADDR_MEPC    = 12'h341;
  localparam logic [11:0]  ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0]  ADDR_MTVAL   = 12'h343;
  // Vectored mode: machine external interrupt (cause 11) lands at base + 4*11.
  localparam logic [N-1:0] IRQ_VEC_OFS  = N'(44);
  localparam logic [N-1:0] IRQ_MCAUSE   = {1'b1, {(N-5){1'b0}}, 4'd11};

  typedef enum logic [2:0] {
    S_IDLE, S_W_EPC, S_W_CAUSE, S_W_TVAL, S_W_STATUS, S_R_STATUS, S_REDIR
  } state_t;

  typedef enum logic [1:0] {K_EXC, K_IRQ, K_MRET} kind_t;

  state_t       state_q, state_d;
  kind_t        kind_q,  kind_d;
  logic [3:0]   cause_q, cause_d;
  logic [N-1:0] pc_q,    pc_d;
  logic [N-1:0] vec_base;

`ifdef CSR_TRAP_TVAL_EN
  logic [N-1:0] tval_q, tval_d;
  // Low PC bits are dropped at capture; low mepc bits are masked on return.
  logic unused_in;
  assign unused_in = ^{exc_pc[1:0], mepc_rd[1:0]};
`else
  logic unused_in;
  assign unused_in = ^{exc_tval, exc_pc[1:0], mepc_rd[1:0]};
`endif

  assign vec_base = {mtvec_rd[N-1:2], 2'b00};

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      kind_q  <= K_EXC;
      cause_q <= '0;
      pc_q    <= '0;
`ifdef CSR_TRAP_TVAL_EN
      tval_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
`ifdef CSR_TRAP_TVAL_EN
      tval_q  <= tval_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    kind_d      = kind_q;
    cause_d     = cause_q;
    pc_d        = pc_q;
`ifdef CSR_TRAP_TVAL_EN
    tval_d      = tval_q;
`endif
    csr_we      = 1'b0;
    csr_addr    = '0;
    csr_wdata   = '0;
    redir_valid = 1'b0;
    redir_pc    = '0;

    case (state_q)
      S_IDLE: begin
        if (exc_req || (irq_req && mstatus_rd[3])) begin
          kind_d  = exc_req ? K_EXC : K_IRQ;
          cause_d = exc_cause;
          pc_d    = {exc_pc[N-1:2], 2'b00};
`ifdef CSR_TRAP_TVAL_EN
          tval_d  = exc_tval;
`endif
          state_d = S_W_EPC;
        end else if (mret_req) begin
          kind_d  = K_MRET;
          state_d = S_R_STATUS;
        end
      end
      S_W_EPC: begin
        csr_we    = 1'b1;
        csr_addr  = ADDR_MEPC;
        csr_wdata = pc_q;
        state_d   = S_W_CAUSE;
      end
      S_W_CAUSE: begin
        csr_we    = 1'b1;
        csr_addr  = ADDR_MCAUSE;
        csr_wdata = (kind_q == K_IRQ) ? IRQ_MCAUSE : {{(N-4){1'b0}}, cause_q};
`ifdef CSR_TRAP_TVAL_EN
        state_d   = S_W_TVAL;
`else
        state_d   = S_W_STATUS;
`endif
      end
`ifdef CSR_TRAP_TVAL_EN
      S_W_TVAL: begin
        csr_we    = 1'b1;
        csr_addr  = ADDR_MTVAL;
        csr_wdata = (kind_q == K_IRQ) ? '0 : tval_q;
        state_d   = S_W_STATUS;
      end
`endif
      S_W_STATUS: begin
        // Trap entry: stack MIE into MPIE, disable interrupts, MPP = M.
        csr_we          = 1'b1;
        csr_addr        = ADDR_MSTATUS;
        csr_wdata       = mstatus_rd;
        csr_wdata[7]    = mstatus_rd[3];
        csr_wdata[3]    = 1'b0;
        csr_wdata[12:11] = 2'b11;
        state_d         = S_REDIR;
      end
      S_R_STATUS: begin
        // mret: restore MIE from MPIE, set MPIE, MPP stays M (M-only core).
        csr_we          = 1'b1;
        csr_addr        = ADDR_MSTATUS;
        csr_wdata       = mstatus_rd;
        csr_wdata[3]    = mstatus_rd[7];
        csr_wdata[7]    = 1'b1;
        csr_wdata[12:11] = 2'b11;
        state_d         = S_REDIR;
      end
      S_REDIR: begin
        redir_valid = 1'b1;
        if (kind_q == K_MRET) begin
          redir_pc = {mepc_rd[N-1:2], 2'b00};
        end else if (kind_q == K_IRQ && mtvec_rd[1:0] == 2'b01) begin
          redir_pc = vec_base + IRQ_VEC_OFS;
        end else begin
          redir_pc = vec_base;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are forced quiet while reset is asserted, even mid-sequence.
    if (rst) begin
      csr_we      = 1'b0;
      csr_addr    = '0;
      csr_wdata   = '0;
      redir_valid = 1'b0;
      redir_pc    = '0;
    end
  end

  assign stall = !rst && (state_q != S_IDLE);

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_csr_trap_ctrl -- directed, table-driven bench for csr_trap_ctrl (N=32).
// Each table row is one clock cycle: inputs are driven just after a rising
// edge and the outputs of that cycle are compared at the following falling
// edge. A hand-written sequence then measures trap latency end to end.
// -----------------------------------------------------------------------------
module tb_csr_trap_ctrl;

  localparam int N = 32;
`ifdef CSR_TRAP_TVAL_EN
  localparam int TRAP_LAT = 5;
  localparam int TRAP_WES = 4;
`else
  localparam int TRAP_LAT = 4;
  localparam int TRAP_WES = 3;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         exc_req;
  logic [3:0]   exc_cause;
  logic [N-1:0] exc_pc, exc_tval;
  logic         irq_req, mret_req;
  logic [N-1:0] mstatus_rd, mtvec_rd, mepc_rd;
  logic         csr_we;
  logic [11:0]  csr_addr;
  logic [N-1:0] csr_wdata;
  logic         stall, redir_valid;
  logic [N-1:0] redir_pc;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  csr_trap_ctrl #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .exc_req    (exc_req),
    .exc_cause  (exc_cause),
    .exc_pc     (exc_pc),
    .exc_tval   (exc_tval),
    .irq_req    (irq_req),
    .mret_req   (mret_req),
    .mstatus_rd (mstatus_rd),
    .mtvec_rd   (mtvec_rd),
    .mepc_rd    (mepc_rd),
    .csr_we     (csr_we),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .stall      (stall),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc)
  );

  typedef struct {
    logic        rst, exc, irq, mret;
    logic [3:0]  cause;
    logic [31:0] pc, tval, mstatus, mtvec, mepc;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        stall, rv;
    logic [31:0] rpc;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic r, e, i, m, input logic [3:0] c,
                     input logic [31:0] pc, tv, ms, mt, me,
                     input logic we, input logic [11:0] a, input logic [31:0] wd,
                     input logic st, rv, input logic [31:0] rp);
    vec_t v;
    v.rst = r; v.exc = e; v.irq = i; v.mret = m; v.cause = c;
    v.pc = pc; v.tval = tv; v.mstatus = ms; v.mtvec = mt; v.mepc = me;
    v.we = we; v.addr = a; v.wdata = wd; v.stall = st; v.rv = rv; v.rpc = rp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s (row %0d): got 0x%08h, want 0x%08h", name, idx, act, exp);
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; exc_req = v.exc; irq_req = v.irq; mret_req = v.mret;
    exc_cause = v.cause; exc_pc = v.pc; exc_tval = v.tval;
    mstatus_rd = v.mstatus; mtvec_rd = v.mtvec; mepc_rd = v.mepc;
  endtask

  task automatic fill();
    // Reset, with and without requests present.
    row(1,0,0,0, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0,0, 0);
    row(1,1,1,1, 2, 32'h100, 0, 32'h8, 0, 0,          0, 0, 0, 0,0, 0);
    // Exception, cause 2, direct vector.
    row(0,1,0,0, 2, 32'h100, 32'hDEADBEEF, 32'h8, 32'h200, 0, 0, 0, 0, 0,0, 0);
    row(0,1,0,0, 2, 32'h100, 32'hDEADBEEF, 32'h8, 32'h200, 0, 1, 12'h341, 32'h100, 1,0, 0);
    row(0,1,0,0, 2, 32'h100, 32'hDEADBEEF, 32'h8, 32'h200, 0, 1, 12'h342, 32'h2, 1,0, 0);
`ifdef CSR_TRAP_TVAL_EN
    row(0,1,0,0, 2, 32'h100, 32'hDEADBEEF, 32'h8, 32'h200, 0, 1, 12'h343, 32'hDEADBEEF, 1,0, 0);
`endif
    row(0,1,0,0, 2, 32'h100, 32'hDEADBEEF, 32'h8, 32'h200, 0, 1, 12'h300, 32'h1880, 1,0, 0);
    row(0,1,0,0, 2, 32'h100, 32'hDEADBEEF, 32'h8, 32'h200, 0, 0, 0, 0, 1,1, 32'h200);
    row(0,0,0,0, 2, 32'h100, 32'hDEADBEEF, 32'h8, 32'h200, 0, 0, 0, 0, 0,0, 0);
    // Interrupt masked by MIE=0.
    row(0,0,1,0, 0, 32'h40, 0, 0, 32'h201, 0,         0, 0, 0, 0,0, 0);
    row(0,0,1,0, 0, 32'h40, 0, 0, 32'h201, 0,         0, 0, 0, 0,0, 0);
    // Interrupt enabled, vectored mtvec.
    row(0,0,1,0, 0, 32'h40, 32'h55, 32'h8, 32'h201, 0, 0, 0, 0, 0,0, 0);
    row(0,0,1,0, 0, 32'h40, 32'h55, 32'h8, 32'h201, 0, 1, 12'h341, 32'h40, 1,0, 0);
    row(0,0,1,0, 0, 32'h40, 32'h55, 32'h8, 32'h201, 0, 1, 12'h342, 32'h8000000B, 1,0, 0);
`ifdef CSR_TRAP_TVAL_EN
    row(0,0,1,0, 0, 32'h40, 32'h55, 32'h8, 32'h201, 0, 1, 12'h343, 32'h0, 1,0, 0);
`endif
    row(0,0,1,0, 0, 32'h40, 32'h55, 32'h8, 32'h201, 0, 1, 12'h300, 32'h1880, 1,0, 0);
    row(0,0,1,0, 0, 32'h40, 32'h55, 32'h8, 32'h201, 0, 0, 0, 0, 1,1, 32'h22C);
    row(0,0,0,0, 0, 32'h40, 32'h55, 32'h8, 32'h201, 0, 0, 0, 0, 0,0, 0);
    // Interrupt with vector offset wrapping past 2^32.
    row(0,0,1,0, 0, 32'h1000, 0, 32'h8, 32'hFFFFFFFD, 0, 0, 0, 0, 0,0, 0);
    row(0,0,1,0, 0, 32'h1000, 0, 32'h8, 32'hFFFFFFFD, 0, 1, 12'h341, 32'h1000, 1,0, 0);
    row(0,0,1,0, 0, 32'h1000, 0, 32'h8, 32'hFFFFFFFD, 0, 1, 12'h342, 32'h8000000B, 1,0, 0);
`ifdef CSR_TRAP_TVAL_EN
    row(0,0,1,0, 0, 32'h1000, 0, 32'h8, 32'hFFFFFFFD, 0, 1, 12'h343, 32'h0, 1,0, 0);
`endif
    row(0,0,1,0, 0, 32'h1000, 0, 32'h8, 32'hFFFFFFFD, 0, 1, 12'h300, 32'h1880, 1,0, 0);
    row(0,0,1,0, 0, 32'h1000, 0, 32'h8, 32'hFFFFFFFD, 0, 0, 0, 0, 1,1, 32'h28);
    row(0,0,0,0, 0, 32'h1000, 0, 32'h8, 32'hFFFFFFFD, 0, 0, 0, 0, 0,0, 0);
    // mret from a trap handler.
    row(0,0,0,1, 0, 0, 0, 32'h1880, 0, 32'h107,       0, 0, 0, 0,0, 0);
    row(0,0,0,1, 0, 0, 0, 32'h1880, 0, 32'h107,       1, 12'h300, 32'h1888, 1,0, 0);
    row(0,0,0,1, 0, 0, 0, 32'h1880, 0, 32'h107,       0, 0, 0, 1,1, 32'h104);
    row(0,0,0,0, 0, 0, 0, 32'h1880, 0, 32'h107,       0, 0, 0, 0,0, 0);
    // mret with MPIE=0 and an all-ones mepc.
    row(0,0,0,1, 0, 0, 0, 0, 0, 32'hFFFFFFFF,         0, 0, 0, 0,0, 0);
    row(0,0,0,1, 0, 0, 0, 0, 0, 32'hFFFFFFFF,         1, 12'h300, 32'h1880, 1,0, 0);
    row(0,0,0,1, 0, 0, 0, 0, 0, 32'hFFFFFFFF,         0, 0, 0, 1,1, 32'hFFFFFFFC);
    row(0,0,0,0, 0, 0, 0, 0, 0, 32'hFFFFFFFF,         0, 0, 0, 0,0, 0);
    // All three requests at once; inputs change during the stall.
    row(0,1,1,1, 5, 32'h102, 32'hABCD, 32'hFFFFFFFF, 32'h201, 0, 0, 0, 0, 0,0, 0);
    row(0,1,1,1, 5, 32'h102, 32'hABCD, 32'hFFFFFFFF, 32'h201, 0, 1, 12'h341, 32'h100, 1,0, 0);
    row(0,0,1,1, 7, 32'h999, 32'h1111, 32'hFFFFFFFF, 32'h201, 0, 1, 12'h342, 32'h5, 1,0, 0);
`ifdef CSR_TRAP_TVAL_EN
    row(0,0,1,1, 7, 32'h999, 32'h1111, 32'hFFFFFFFF, 32'h201, 0, 1, 12'h343, 32'hABCD, 1,0, 0);
`endif
    row(0,0,1,1, 7, 32'h999, 32'h1111, 32'hFFFFFFFF, 32'h201, 0, 1, 12'h300, 32'hFFFFFFF7, 1,0, 0);
    row(0,0,1,1, 7, 32'h999, 32'h1111, 32'hFFFFFFFF, 32'h201, 0, 0, 0, 0, 1,1, 32'h200);
    row(0,0,0,0, 7, 32'h999, 32'h1111, 32'hFFFFFFFF, 32'h201, 0, 0, 0, 0, 0,0, 0);
    // Reset during W_CAUSE, then a fresh exception restarts at W_EPC.
    row(0,1,0,0, 4, 32'h300, 0, 32'h8, 32'h200, 0,    0, 0, 0, 0,0, 0);
    row(0,1,0,0, 4, 32'h300, 0, 32'h8, 32'h200, 0,    1, 12'h341, 32'h300, 1,0, 0);
    row(1,1,0,0, 4, 32'h300, 0, 32'h8, 32'h200, 0,    0, 0, 0, 0,0, 0);
    row(0,0,0,0, 4, 32'h300, 0, 32'h8, 32'h200, 0,    0, 0, 0, 0,0, 0);
    row(0,0,0,0, 4, 32'h300, 0, 32'h8, 32'h200, 0,    0, 0, 0, 0,0, 0);
    row(0,1,0,0, 6, 32'h500, 0, 32'h8, 32'h200, 0,    0, 0, 0, 0,0, 0);
    row(0,1,0,0, 6, 32'h500, 0, 32'h8, 32'h200, 0,    1, 12'h341, 32'h500, 1,0, 0);
    row(0,1,0,0, 6, 32'h500, 0, 32'h8, 32'h200, 0,    1, 12'h342, 32'h6, 1,0, 0);
    row(1,0,0,0, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0,0, 0);
    row(0,0,0,0, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0,0, 0);
  endtask

  initial begin
    vec_t v;
    int   lat;
    int   we_cnt;
    logic [31:0] got_pc;

    v = '{default: '0};
    v.rst = 1'b1;
    drive(v);
    fill();

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k]);
      @(negedge clk);
      check("csr_we",      k, 32'(csr_we),      32'(vecs[k].we));
      check("csr_addr",    k, 32'(csr_addr),    32'(vecs[k].addr));
      check("csr_wdata",   k, csr_wdata,        vecs[k].wdata);
      check("stall",       k, 32'(stall),       32'(vecs[k].stall));
      check("redir_valid", k, 32'(redir_valid), 32'(vecs[k].rv));
      check("redir_pc",    k, redir_pc,         vecs[k].rpc);
      @(posedge clk);
      #1;
    end

    // Latency: exception accepted at cycle 0, redirect strobe TRAP_LAT later.
    v = '{default: '0};
    v.exc = 1'b1; v.cause = 4'd3; v.pc = 32'h204; v.mstatus = 32'h8; v.mtvec = 32'h400;
    drive(v);
    lat    = -1;
    we_cnt = 0;
    got_pc = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (csr_we) we_cnt++;
      if (redir_valid) begin
        lat    = k;
        got_pc = redir_pc;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("trap_latency",   -1, 32'(lat),    32'(TRAP_LAT));
    check("trap_write_cnt", -1, 32'(we_cnt), 32'(TRAP_WES));
    check("trap_redir_pc",  -1, got_pc,      32'h400);
    v.exc = 1'b0;
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    check("redir_one_cycle", -1, 32'(redir_valid), 32'd0);
    check("stall_released",  -1, 32'(stall),       32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
- Trap sequencer for the machine-mode CSR file. It takes synchronous exceptions, external interrupts and mret requests from the core.
- It drives the single CSR write port, one write per cycle, to save and restore trap state (mepc, mcause, mstatus, optionally mtval).
- It stalls the pipeline for the whole sequence, then issues a one-cycle PC redirect to the trap vector or to the return address.

Parameters:
N, 32, datapath and CSR width.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
exc_req  in  1  synchronous exception request, level, sampled in IDLE only
exc_cause  in  4  exception cause code
exc_pc  in  N  PC of faulting instruction
exc_tval  in  N  trap value (bad address/instruction)
irq_req  in  1  machine external interrupt pending, level
mret_req  in  1  mret retiring
mstatus_rd  in  N  current mstatus value
mtvec_rd  in  N  current mtvec value
mepc_rd  in  N  current mepc value
csr_we  out  1  CSR write enable
csr_addr  out  12  CSR write address
csr_wdata  out  N  CSR write data
stall  out  1  pipeline hold
redir_valid  out  1  one-cycle PC redirect strobe
redir_pc  out  N  redirect target

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, capture registers cleared.
- In reset, all outputs are 0.
- Reset mid-sequence returns to IDLE on that edge. No further csr_we and no redir_valid are issued.
- States: IDLE, W_EPC, W_CAUSE, [W_TVAL], W_STATUS, R_STATUS, REDIR.
- IDLE acceptance priority:
  - 1) exc_req.
  - 2) irq_req, only when mstatus_rd[3] (MIE)=1.
  - 3) mret_req.
- Requests are ignored in any other state. Sources hold while stall=1.
- On acceptance: latch kind (exception or interrupt), cause, exc_pc and exc_tval.
- Transitions on acceptance:
  - exception or interrupt: next state W_EPC.
  - mret: next state R_STATUS.
- stall=1 whenever state != IDLE. stall=0 in IDLE, including the acceptance cycle; the next stage is frozen from the following cycle.
- W_EPC: csr_we=1, addr 0x341, wdata = latched pc with bits[1:0] forced to 0. Interrupts use exc_pc as the resume PC.
- W_CAUSE: csr_we=1, addr 0x342.
  - exception: wdata = {1'b0, zero-extended cause}.
  - interrupt: wdata = {1'b1, ..., 11}, i.e. 0x8000000B for N=32.
- W_STATUS (trap entry): csr_we=1, addr 0x300, wdata = mstatus_rd with:
  - MPIE[7] = MIE[3];
  - MIE[3] = 0;
  - MPP[12:11] = 2'b11;
  - all other bits preserved.
- R_STATUS (mret): csr_we=1, addr 0x300, wdata = mstatus_rd with:
  - MIE[3] = MPIE[7];
  - MPIE[7] = 1;
  - MPP[12:11] = 2'b11.
- REDIR: redir_valid=1 for exactly one cycle, csr_we=0, then IDLE.
- Redirect target after a trap:
  - base = {mtvec_rd[N-1:2], 2'b00}.
  - If mtvec_rd[1:0]==01 and the trap is an interrupt: redir_pc = base + 4*11.
  - Otherwise: redir_pc = base.
  - Addition is modulo 2^N.
- Redirect target after mret: redir_pc = {mepc_rd[N-1:2], 2'b00}.
- mtvec, mstatus and mepc are read combinationally in the state that uses them.
- Latency, exception/interrupt: accept at cycle 0, writes at cycles 1-3, redir at cycle 4, IDLE at cycle 5.
- Latency, mret: accept at cycle 0, write at cycle 1, redir at cycle 2, IDLE at cycle 3.
- Outside the write states, csr_we=0 and csr_addr/csr_wdata=0.
- redir_pc=0 when redir_valid=0.

Optional Feature:
CSR_TRAP_TVAL_EN:
- Defined: W_TVAL is inserted between W_CAUSE and W_STATUS.
  - W_TVAL: csr_we=1, addr 0x343, wdata = latched exc_tval for exceptions, 0 for interrupts.
  - Trap latency becomes redir at cycle 5.
- Undefined: no W_TVAL state, mtval is never written, exc_tval is unused.

Test Plan:
- Exception: exc_req=1, cause=2, exc_pc=0x100, mstatus_rd=0x8, mtvec_rd=0x200.
  -> writes 0x341<=0x100, 0x342<=0x2, 0x300<=0x1880 on cycles 1-3.
  -> redir_valid at cycle 4 with redir_pc=0x200.
  -> stall high on cycles 1-4.
- Interrupt masked: irq_req=1, mstatus_rd=0x0 -> no csr_we, stall stays 0.
- Interrupt enabled: mstatus_rd=0x8, mtvec_rd=0x201, exc_pc=0x40.
  -> mcause<=0x8000000B, mepc<=0x40.
  -> redir_pc=0x22C.
- mret: mstatus_rd=0x1880, mepc_rd=0x107.
  -> cycle 1 writes 0x300<=0x1888.
  -> cycle 2 redir_pc=0x104.
- Simultaneous requests: exc_req, irq_req (MIE=1) and mret_req all high -> exception sequence only, mcause bit31=0. Requests changed during stall have no effect.
- Reset mid-operation: rst=1 during W_CAUSE.
  -> next cycle csr_we=0, stall=0, no redir_valid.
  -> a fresh exc_req after reset restarts at W_EPC.
